// File: rtl/word_byte_splitter_if.sv
// Handshake bundle between a word-wide producer and a byte-wide consumer.
// The splitter sits on the slave modport; the environment drives the master side.
interface word_byte_splitter_if #(
    parameter int BYTE_W = 8,
    parameter int BYTES  = 2
);
    localparam int IDX_W = $clog2(BYTES);

    logic                    in_valid;
    logic                    in_ready;
    logic [BYTES*BYTE_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [BYTE_W-1:0]       out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic [BYTE_W-1:0]       out_or;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_or
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_or
    );
endinterface

// File: rtl/word_byte_splitter.sv
// Unpacks a word of BYTES concatenated lanes into one byte per handshake,
// with a running OR of the bytes of the current word emitted so far.
module word_byte_splitter #(
    parameter int BYTE_W    = 8,
    parameter int BYTES     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    word_byte_splitter_if.slave  bus
);
    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  r_state;
    logic [BYTES*BYTE_W-1:0] r_word;
    logic [IDX_W-1:0]        r_idx;
    logic [BYTE_W-1:0]       r_acc;

    logic [IDX_W-1:0]        w_lane;
    logic [BYTE_W-1:0]       w_data;
    logic                    w_valid;
    logic                    w_last;
    logic                    w_fire;
    logic                    w_in_ready;

    // Emission index counts 0..BYTES-1; the physical lane reverses when MSB leads.
    assign w_lane = (MSB_FIRST != 0) ? (LAST_IDX - r_idx) : r_idx;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (w_lane == IDX_W'(i)) begin
                w_data = r_word[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_valid    = (r_state == SEND);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_fire     = w_valid && bus.out_ready;
    assign w_in_ready = (r_state == IDLE) || (w_fire && w_last);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_last;
    assign bus.out_or    = r_acc | w_data;

    // A final-beat handshake with a waiting word reloads directly, so there is no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_word  <= bus.in_data;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_fire) begin
                        if (!w_last) begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_acc <= r_acc | w_data;
                        end else if (bus.in_valid) begin
                            r_word <= bus.in_data;
                            r_idx  <= '0;
                            r_acc  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_word_byte_splitter.sv
// Bench for word_byte_splitter: directed scenarios on three parameterisations
// plus a randomized run against a queue-based byte-stream model.
module tb_word_byte_splitter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    word_byte_splitter_if #(.BYTE_W(8), .BYTES(2)) ifA ();
    word_byte_splitter_if #(.BYTE_W(8), .BYTES(2)) ifB ();
    word_byte_splitter_if #(.BYTE_W(8), .BYTES(4)) ifC ();

    word_byte_splitter #(.BYTE_W(8), .BYTES(2), .MSB_FIRST(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
    word_byte_splitter #(.BYTE_W(8), .BYTES(2), .MSB_FIRST(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));
    word_byte_splitter #(.BYTE_W(8), .BYTES(4), .MSB_FIRST(1)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC.slave));

    // Packed observation: {valid, idx, last, data, or}
    logic [18:0] obsA;
    logic [18:0] obsB;
    logic [19:0] obsC;
    assign obsA = {ifA.out_valid, ifA.out_idx, ifA.out_last, ifA.out_data, ifA.out_or};
    assign obsB = {ifB.out_valid, ifB.out_idx, ifB.out_last, ifB.out_data, ifB.out_or};
    assign obsC = {ifC.out_valid, ifC.out_idx, ifC.out_last, ifC.out_data, ifC.out_or};

    typedef struct packed {
        logic       idx;
        logic       last;
        logic [7:0] data;
        logic [7:0] orv;
    } beat_t;

    beat_t q[$];

    task automatic test_reset();
        #12;
        checks++; if (obsA !== 19'h0) begin errors++; $display("[TB] FAIL reset_outA: got %h want %h", obsA, 19'h0); end
        checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_readyA: got %b want 1", ifA.in_ready); end
        checks++; if (obsB !== 19'h0) begin errors++; $display("[TB] FAIL reset_outB: got %h want %h", obsB, 19'h0); end
        checks++; if (obsC !== 20'h0) begin errors++; $display("[TB] FAIL reset_outC: got %h want %h", obsC, 20'h0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        ifA.in_valid = 1'b1; ifA.in_data = 16'hA55A; ifA.out_ready = 1'b1;
        #1;
        checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle_ready: got %b want 1", ifA.in_ready); end
        checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency: got %b want 0", ifA.out_valid); end
        @(negedge clk);
        ifA.in_valid = 1'b0;
        #1;
        checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5}) begin errors++; $display("[TB] FAIL basic_beat0: got %h want %h", obsA, {1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5}); end
        checks++; if (ifA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready0: got %b want 0", ifA.in_ready); end
        @(negedge clk); #1;
        checks++; if (obsA !== {1'b1, 1'b1, 1'b1, 8'h5A, 8'hFF}) begin errors++; $display("[TB] FAIL basic_beat1: got %h want %h", obsA, {1'b1, 1'b1, 1'b1, 8'h5A, 8'hFF}); end
        checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready1: got %b want 1", ifA.in_ready); end
        @(negedge clk); #1;
        checks++; if (ifA.out_valid !== 1'b0 || ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got valid=%b ready=%b want valid=0 ready=1", ifA.out_valid, ifA.in_ready); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ifA.in_valid = 1'b1; ifA.in_data = 16'h1234; ifA.out_ready = 1'b0;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'h12, 8'h12}) begin errors++; $display("[TB] FAIL bp_hold%0d: got %h want %h", i, obsA, {1'b1, 1'b0, 1'b0, 8'h12, 8'h12}); end
            checks++; if (ifA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready%0d: got %b want 0", i, ifA.in_ready); end
            @(negedge clk);
        end
        ifA.out_ready = 1'b1;
        #1;
        checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'h12, 8'h12}) begin errors++; $display("[TB] FAIL bp_beat0: got %h want %h", obsA, {1'b1, 1'b0, 1'b0, 8'h12, 8'h12}); end
        @(negedge clk); #1;
        checks++; if (obsA !== {1'b1, 1'b1, 1'b1, 8'h34, 8'h36}) begin errors++; $display("[TB] FAIL bp_beat1: got %h want %h", obsA, {1'b1, 1'b1, 1'b1, 8'h34, 8'h36}); end
        @(negedge clk); #1;
        checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_done: got %b want 0", ifA.out_valid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ifA.in_valid = 1'b1; ifA.in_data = 16'h0102; ifA.out_ready = 1'b1;
        @(negedge clk);
        ifA.in_data = 16'h0304;
        #1;
        checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'h01, 8'h01} || ifA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_01: got %h rdy=%b want %h rdy=0", obsA, ifA.in_ready, {1'b1, 1'b0, 1'b0, 8'h01, 8'h01}); end
        @(negedge clk); #1;
        checks++; if (obsA !== {1'b1, 1'b1, 1'b1, 8'h02, 8'h03} || ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_02: got %h rdy=%b want %h rdy=1", obsA, ifA.in_ready, {1'b1, 1'b1, 1'b1, 8'h02, 8'h03}); end
        @(negedge clk);
        ifA.in_valid = 1'b0;
        #1;
        checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'h03, 8'h03} || ifA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_03: got %h rdy=%b want %h rdy=0", obsA, ifA.in_ready, {1'b1, 1'b0, 1'b0, 8'h03, 8'h03}); end
        @(negedge clk); #1;
        checks++; if (obsA !== {1'b1, 1'b1, 1'b1, 8'h04, 8'h07} || ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_04: got %h rdy=%b want %h rdy=1", obsA, ifA.in_ready, {1'b1, 1'b1, 1'b1, 8'h04, 8'h07}); end
        @(negedge clk); #1;
        checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got %b want 0", ifA.out_valid); end
    endtask

    task automatic test_lsb_first();
        @(negedge clk);
        ifB.in_valid = 1'b1; ifB.in_data = 16'hA55A; ifB.out_ready = 1'b1;
        @(negedge clk);
        ifB.in_valid = 1'b0;
        #1;
        checks++; if (obsB !== {1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A}) begin errors++; $display("[TB] FAIL lsb_beat0: got %h want %h", obsB, {1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A}); end
        @(negedge clk); #1;
        checks++; if (obsB !== {1'b1, 1'b1, 1'b1, 8'hA5, 8'hFF}) begin errors++; $display("[TB] FAIL lsb_beat1: got %h want %h", obsB, {1'b1, 1'b1, 1'b1, 8'hA5, 8'hFF}); end
        @(negedge clk); #1;
        checks++; if (ifB.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lsb_done: got %b want 0", ifB.out_valid); end
    endtask

    task automatic test_reset_mid_word();
        @(negedge clk);
        ifA.in_valid = 1'b1; ifA.in_data = 16'hBEEF; ifA.out_ready = 1'b1;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        #1;
        checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'hBE, 8'hBE}) begin errors++; $display("[TB] FAIL rst_beat0: got %h want %h", obsA, {1'b1, 1'b0, 1'b0, 8'hBE, 8'hBE}); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (obsA !== 19'h0 || ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_async: got %h rdy=%b want 0 rdy=1", obsA, ifA.in_ready); end
        @(negedge clk); #1;
        checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_ef: got %b want 0", ifA.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        ifA.in_valid = 1'b1; ifA.in_data = 16'h00C3;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        #1;
        checks++; if (obsA !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin errors++; $display("[TB] FAIL rst_next0: got %h want %h", obsA, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}); end
        @(negedge clk); #1;
        checks++; if (obsA !== {1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3}) begin errors++; $display("[TB] FAIL rst_next1: got %h want %h", obsA, {1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3}); end
        @(negedge clk);
    endtask

    task automatic test_four_lanes();
        logic [7:0] expData [4];
        logic [7:0] expOr   [4];
        expData = '{8'h01, 8'h02, 8'h04, 8'h08};
        expOr   = '{8'h01, 8'h03, 8'h07, 8'h0F};
        @(negedge clk);
        ifC.in_valid = 1'b1; ifC.in_data = 32'h01020408; ifC.out_ready = 1'b1;
        @(negedge clk);
        ifC.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (obsC !== {1'b1, 2'(k), (k == 3), expData[k], expOr[k]}) begin errors++; $display("[TB] FAIL four_beat%0d: got %h want %h", k, obsC, {1'b1, 2'(k), (k == 3), expData[k], expOr[k]}); end
            @(negedge clk);
        end
        #1;
        checks++; if (ifC.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL four_done: got %b want 0", ifC.out_valid); end
    endtask

    // Model: every accepted word becomes two queued beats, MSB lane first.
    task automatic test_random();
        logic       expValid;
        logic       expReady;
        logic [7:0] b;
        logic [7:0] acc;
        beat_t      e;
        q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc < 280) begin
                ifA.in_valid  = 1'($urandom_range(0, 1));
                ifA.in_data   = 16'($urandom);
                ifA.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                ifA.in_valid  = 1'b0;
                ifA.out_ready = 1'b1;
            end
            #1;
            expValid = (q.size() != 0);
            expReady = (q.size() == 0) || (ifA.out_ready && q[0].last);
            checks++; if (ifA.out_valid !== expValid) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", cyc, ifA.out_valid, expValid); end
            checks++; if (ifA.in_ready !== expReady) begin errors++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, ifA.in_ready, expReady); end
            if (expValid) begin
                e = q[0];
                checks++; if (obsA !== {1'b1, e.idx, e.last, e.data, e.orv}) begin errors++; $display("[TB] FAIL rand_beat@%0d: got %h want %h", cyc, obsA, {1'b1, e.idx, e.last, e.data, e.orv}); end
                if (ifA.out_ready) void'(q.pop_front());
            end
            if (ifA.in_valid && expReady) begin
                acc = 8'h00;
                for (int k = 0; k < 2; k++) begin
                    b = 8'((ifA.in_data >> ((1 - k) * 8)) & 16'h00FF);
                    acc = acc | b;
                    q.push_back('{idx: 1'(k), last: (k == 1), data: b, orv: acc});
                end
            end
        end
    endtask

    initial begin
        ifA.in_valid = 1'b0; ifA.in_data = '0; ifA.out_ready = 1'b0;
        ifB.in_valid = 1'b0; ifB.in_data = '0; ifB.out_ready = 1'b0;
        ifC.in_valid = 1'b0; ifC.in_data = '0; ifC.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_lsb_first();
        test_four_lanes();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/word_byte_splitter.md
Name: word_byte_splitter

Overview:
- Splits a parallel word of BYTES concatenated bytes back into a stream of single bytes, one per handshake.
- It is the unpacking end of the byte-concatenation datapath: bytes joined as {a, b} on the producer side are recovered here as a, then b.
- It also provides a running OR of the bytes emitted so far, so the consumer sees the full OR-of-parts on the last beat.
- It sits between a word-wide producer and a byte-wide consumer, each with a valid/ready handshake.

Parameters:
- BYTE_W, 8, width of one byte lane in bits.
- BYTES, 2, number of byte lanes per input word (≥2).
- MSB_FIRST, 1. When 1, the most-significant lane (bits [BYTES*BYTE_W-1 -: BYTE_W]) is emitted first. When 0, lane [BYTE_W-1:0] is emitted first.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  splitter accepts the word this cycle.
- in_data  input  BYTES*BYTE_W  concatenated word.
- out_valid  output  1  byte available.
- out_ready  input  1  consumer accepts the byte this cycle.
- out_data  output  BYTE_W  current byte.
- out_idx  output  clog2(BYTES)  emission index, 0..BYTES-1.
- out_last  output  1  current byte is the final lane of its word.
- out_or  output  BYTE_W  OR of all bytes of the current word up to and including out_data.

Behaviour:
- Reset is asynchronous on rst_n low. Required reset state:
  - out_valid=0, in_ready=1.
  - Index, word register and OR accumulator all 0.
  - As a result, out_idx=0, out_data=0, out_last=0, out_or=0.
- State machine has two states.
  - IDLE: no word held.
  - SEND: word held, out_valid=1.
- IDLE → SEND on in_valid && in_ready. On that transition:
  - Latch in_data into the word register.
  - Set idx=0 and acc=0.
- First-byte latency: out_valid rises the cycle after the input handshake. There is no combinational path from in_data to out_data.
- out_data is the word-register lane selected by idx and MSB_FIRST. out_last = (idx == BYTES-1). out_or = acc | out_data (combinational from registers).
- In SEND, the output handshake (out_valid && out_ready) behaves as follows:
  - Not last: idx += 1 and acc |= out_data.
  - Last, with in_valid=1: load the new word, idx=0, acc=0, stay in SEND. Back-to-back words have no bubble cycle.
  - Last, with in_valid=0: go to IDLE with out_valid=0.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - The combinational path out_ready → in_ready is intentional.
  - in_ready never depends on in_valid.
- Backpressure: while out_valid && !out_ready, the following hold stable: out_data, out_idx, out_last, out_or and the word register.
- in_data is ignored whenever in_ready=0.
- idx never exceeds BYTES-1; it wraps only via reload to 0.
- Reset asserted mid-word: the word in progress is discarded with no further beats, and all outputs take their reset values immediately.
- Deassertion of rst_n is sampled synchronously by the design.
- All state is updated in a single clocked process. Output logic is purely combinational from state. No latches.

Test Plan:
- Reset, then in_data=16'hA55A with in_valid pulse, out_ready=1 (MSB_FIRST=1). Required:
  - Beat 0: out_data=8'hA5, out_idx=0, out_last=0, out_or=8'hA5.
  - Beat 1: out_data=8'h5A, out_last=1, out_or=8'hFF.
  - Then out_valid=0 and in_ready=1.
- Backpressure: word 16'h1234, out_ready held 0 for 5 cycles. Required:
  - out_data stays 8'h12 and in_ready stays 0.
  - After release: 8'h12 then 8'h34, out_or=8'h36 on the last beat.
- Back-to-back: in_valid held 1 with words 16'h0102 then 16'h0304, out_ready=1. Required: bytes 01,02,03,04 on consecutive cycles, no bubble; in_ready=1 only on cycles where 02 or 04 is accepted.
- MSB_FIRST=0 with word 16'hA55A. Required: 8'h5A emitted first, then 8'hA5; out_or final = 8'hFF.
- Reset mid-word: assert rst_n=0 after beat 0 of 16'hBEEF. Required:
  - out_valid=0 asynchronously and no 8'hEF beat.
  - A next word 16'h00C3 emits 00 then C3, out_or=8'hC3.
- BYTES=4 with word 32'h01020408. Required: idx 0..3 emits 01,02,04,08; out_last only on idx 3; out_or sequence 01,03,07,0F.
